ser_link_scheduler: RTL and testbench



---
 rtl/ser_sched_pkg.sv | 23 ++
 rtl/ser_rr_arbiter.sv | 32 +++
 rtl/ser_link_scheduler.sv | 119 +++++++++++
 tb/tb_ser_link_scheduler.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ser_sched_pkg.sv
// Shared types and constants for the serializer link scheduler.
package ser_sched_pkg;

  localparam int BYTE_W      = 8;
  localparam int FRAME_CNT_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    LOAD,
    WAIT,
    GAP
  } state_t;

  // Index width for a channel count; never narrower than one bit.
  function automatic int sched_clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/ser_rr_arbiter.sv
// Combinational round-robin pick: first valid requester after ptr, with wrap.
module ser_rr_arbiter
  import ser_sched_pkg::*;
#(
  parameter int NUM_REQ = 2,
  localparam int IDX_W = sched_clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   ptr,
  output logic               any,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IDX_W-1:0]   idx
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    any    = 1'b0;
    idx    = '0;
    onehot = '0;
    cand   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((int'(ptr) + i) % NUM_REQ);
      if (!any && valid[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
    if (any) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/ser_link_scheduler.sv
// Shares one byte serializer among NUM_REQ requesters: grant, load, wait for done, gap.
// All outputs registered; timeout_err is sticky and frame_cnt counts completed frames.
module ser_link_scheduler
  import ser_sched_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 64,
  localparam int IDX_W = sched_clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [BYTE_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [BYTE_W-1:0]         ser_data,
  output logic                      ser_load,
  input  logic                      ser_done,
  output logic [IDX_W-1:0]          grant_id,
  output logic                      busy,
  output logic                      timeout_err,
  input  logic                      clr_err,
  output logic [FRAME_CNT_W-1:0]    frame_cnt
);

  localparam int TO_W = sched_clog2(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] GAP_LAST = 4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam state_t POST_WAIT = (GAP_CYCLES == 0) ? IDLE : GAP;

  state_t             state;
  logic [IDX_W-1:0]   ptr;
  logic [TO_W-1:0]    to_cnt;
  logic [3:0]         gap_cnt;
  logic               arb_any;
  logic [NUM_REQ-1:0] arb_onehot;
  logic [IDX_W-1:0]   arb_idx;
  logic [BYTE_W-1:0]  sel_byte;

  ser_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .valid  (req_valid),
    .ptr    (ptr),
    .any    (arb_any),
    .onehot (arb_onehot),
    .idx    (arb_idx)
  );

  always_comb begin
    sel_byte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == IDX_W'(i)) sel_byte = req_data[i*BYTE_W +: BYTE_W];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= IDX_W'(NUM_REQ - 1);
      grant_id    <= '0;
      req_ready   <= '0;
      ser_data    <= '0;
      ser_load    <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      frame_cnt   <= '0;
      to_cnt      <= '0;
      gap_cnt     <= '0;
    end else begin
      req_ready <= '0;
      ser_load  <= 1'b0;
      // A timeout in the WAIT branch below overrides this same-cycle clear.
      if (clr_err) timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (arb_any) begin
            state     <= GRANT;
            grant_id  <= arb_idx;
            req_ready <= arb_onehot;
            busy      <= 1'b1;
          end
        end
        GRANT: begin
          ser_data <= sel_byte;
          ptr      <= grant_id;
          ser_load <= 1'b1;
          state    <= LOAD;
        end
        LOAD: begin
          to_cnt <= '0;
          state  <= WAIT;
        end
        WAIT: begin
          if (ser_done || to_cnt == TO_LAST) begin
            if (ser_done) frame_cnt <= frame_cnt + 1'b1;
            else          timeout_err <= 1'b1;
            gap_cnt <= '0;
            state   <= POST_WAIT;
            busy    <= (POST_WAIT != IDLE);
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ser_link_scheduler.sv
// Scoreboard bench: a round-robin reference model predicts the byte stream, a monitor checks each load.
module tb_ser_link_scheduler;

  localparam int NR  = 3;
  localparam int GAP = 2;
  localparam int TO  = 64;
  localparam int IW  = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [NR-1:0]   req_valid;
  logic [8*NR-1:0] req_data;
  logic [NR-1:0]   req_ready;
  logic [7:0]      ser_data;
  logic            ser_load;
  logic            ser_done;
  logic [IW-1:0]   grant_id;
  logic            busy;
  logic            timeout_err;
  logic            clr_err;
  logic [15:0]     frame_cnt;

  ser_link_scheduler #(.NUM_REQ(NR), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .ser_data(ser_data), .ser_load(ser_load), .ser_done(ser_done),
    .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err), .clr_err(clr_err),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ch;
    int dat;
  } exp_t;

  exp_t        expq[$];
  int          chq[NR][$];
  int          pend[NR][$];
  int          vld_cyc[NR];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          model_ptr = NR - 1;
  int          frames = 0;
  int          done_delay = 5;
  bit          dbl = 1'b0;
  bit          dbl_pend = 1'b0;
  int          stray = 0;
  int          sd_cnt = 0;
  logic [NR-1:0] take = '0;
  logic [NR-1:0] prev_ready = '0;
  exp_t        mon_e;
  int          lc, ec, rc;
  bit          seen, ok;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired (cycle %0d)", nm, cyc);
  endtask

  // Reference: every requester with bytes left is valid; the link serves them in
  // round-robin order starting after the last channel served.
  task automatic commit();
    int   c;
    bit   found;
    exp_t e;
    while (1) begin
      found = 1'b0;
      for (int k = 1; k <= NR && !found; k++) begin
        c = (model_ptr + k) % NR;
        if (pend[c].size() > 0) begin
          found = 1'b1;
          e.ch  = c;
          e.dat = pend[c][0];
          expq.push_back(e);
          chq[c].push_back(pend[c].pop_front());
          model_ptr = c;
          if (done_delay >= 1 && done_delay <= TO) frames++;
        end
      end
      if (!found) break;
    end
  endtask

  task automatic wait_idle(input string nm);
    bit done;
    done = 1'b0;
    for (int t = 0; t < 3000 && !done; t++) begin
      @(negedge clk);
      done = (expq.size() == 0) && !busy && !ser_load;
      for (int i = 0; i < NR; i++) if (chq[i].size() != 0) done = 1'b0;
    end
    if (!done) timeout_fail(nm);
    @(negedge clk);
  endtask

  task automatic wait_load(input string nm, output int lcyc);
    lcyc = -1;
    for (int t = 0; t < 300 && lcyc < 0; t++) begin
      @(negedge clk);
      if (ser_load) lcyc = cyc;
    end
    if (lcyc < 0) timeout_fail(nm);
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Requester side: hold each channel's front byte until it is accepted.
  initial begin
    req_valid = '0;
    req_data  = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NR; i++) begin
        if (take[i] && chq[i].size() > 0) void'(chq[i].pop_front());
        if (chq[i].size() > 0) begin
          if (!req_valid[i]) vld_cyc[i] = cyc;
          req_valid[i] = 1'b1;
          req_data[i*8 +: 8] = 8'(chq[i][0]);
        end else begin
          req_valid[i] = 1'b0;
        end
      end
      take = req_ready;
    end
  end

  // Serializer model: ser_done done_delay cycles after each load (0 = never).
  initial begin
    ser_done = 1'b0;
    forever begin
      @(negedge clk);
      ser_done = 1'b0;
      if (reset) sd_cnt = 0;
      if (stray > 0) begin
        ser_done = 1'b1;
        stray--;
      end else if (dbl_pend) begin
        ser_done = 1'b1;
        dbl_pend = 1'b0;
      end
      if (sd_cnt > 0) begin
        sd_cnt--;
        if (sd_cnt == 0) begin
          ser_done = 1'b1;
          if (dbl) dbl_pend = 1'b1;
        end
      end
      if (ser_load && done_delay > 0) sd_cnt = done_delay;
    end
  end

  // Monitor: every load must match the next predicted (channel, byte).
  initial begin
    forever begin
      @(negedge clk);
      if (req_ready != '0) begin
        check("ready_onehot", req_ready, 32'd1 << grant_id);
        check("busy_in_grant", busy, 1);
      end
      if (ser_load) begin
        check("load_after_ready", prev_ready, 32'd1 << grant_id);
        if (expq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_load: got data %0h ch %0d expected no load", ser_data, grant_id);
        end else begin
          mon_e = expq.pop_front();
          check("ser_data", ser_data, mon_e.dat);
          check("grant_id", grant_id, mon_e.ch);
        end
      end
      prev_ready = req_ready;
    end
  end

  initial begin
    reset   = 1'b1;
    clr_err = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", req_ready, 0);
    check("rst_load", ser_load, 0);
    check("rst_busy", busy, 0);
    check("rst_data", ser_data, 0);
    check("rst_err", timeout_err, 0);
    check("rst_cnt", frame_cnt, 0);
    check("rst_gid", grant_id, 0);
    reset = 1'b0;
    @(negedge clk);

    // Contention straight after reset: channel 0 goes first, then alternation.
    done_delay = 3;
    pend[0].push_back('h11); pend[0].push_back('h11);
    pend[1].push_back('h22); pend[1].push_back('h22);
    commit();
    wait_idle("t2_drain");
    check("t2_frames", frame_cnt, 16'(frames));

    // Single request: latency and gap timing.
    done_delay = 10;
    pend[0].push_back('hA5);
    commit();
    rc = -1;
    for (int t = 0; t < 50 && rc < 0; t++) begin
      @(negedge clk);
      if (req_ready != '0) rc = cyc;
    end
    if (rc < 0) timeout_fail("t1_ready_wait");
    else begin
      check("t1_ready_latency", rc - vld_cyc[0], 1);
      check("t1_ready", req_ready, 3'b001);
      @(negedge clk);
      check("t1_load", ser_load, 1);
      lc = cyc;
      wait_to(lc + 11);
      check("t1_cnt", frame_cnt, 16'(frames));
      check("t1_busy_gap0", busy, 1);
      wait_to(lc + 12);
      check("t1_busy_gap1", busy, 1);
      wait_to(lc + 13);
      check("t1_busy_idle", busy, 0);
    end
    wait_idle("t1_drain");

    // Timeout: no done; error becomes visible after the 64th WAIT cycle ends.
    done_delay = 0;
    pend[0].push_back('h3C);
    commit();
    wait_load("t3_load", lc);
    ec = -1;
    for (int t = 0; t < 200 && ec < 0; t++) begin
      @(negedge clk);
      if (timeout_err) ec = cyc;
    end
    if (ec < 0) timeout_fail("t3_err_wait");
    else check("t3_err_cycle", ec - lc, TO + 1);
    check("t3_cnt_same", frame_cnt, 16'(frames));
    wait_idle("t3_drain");
    check("t3_err_sticky", timeout_err, 1);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    check("t3_err_cleared", timeout_err, 0);

    // Set beats a clear held high across the timeout.
    clr_err = 1'b1;
    pend[2].push_back('h3D);
    commit();
    wait_load("t3b_load", lc);
    wait_to(lc + TO + 1);
    check("t3_set_wins", timeout_err, 1);
    @(negedge clk);
    check("t3_clear_after", timeout_err, 0);
    clr_err = 1'b0;
    wait_idle("t3b_drain");

    done_delay = 4;
    pend[1].push_back('h3E);
    commit();
    wait_idle("t3c_drain");
    check("t3_next_ok_cnt", frame_cnt, 16'(frames));
    check("t3_next_ok_err", timeout_err, 0);

    // Done on the last WAIT cycle wins; one cycle later is a timeout.
    done_delay = TO;
    pend[0].push_back('h4D);
    commit();
    seen = 1'b0;
    for (int t = 0; t < 120; t++) begin
      @(negedge clk);
      if (timeout_err) seen = 1'b1;
    end
    check("t4_no_err", seen, 0);
    check("t4_cnt", frame_cnt, 16'(frames));
    wait_idle("t4_drain");
    done_delay = TO + 1;
    pend[1].push_back('h4E);
    commit();
    wait_idle("t4b_drain");
    check("t4_late_err", timeout_err, 1);
    check("t4_late_cnt", frame_cnt, 16'(frames));
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;

    // Reset three cycles into WAIT.
    done_delay = 0;
    pend[0].push_back('h5A);
    commit();
    wait_load("t5_load", lc);
    wait_to(lc + 3);
    reset = 1'b1;
    #1;
    check("t5_load0", ser_load, 0);
    check("t5_ready0", req_ready, 0);
    check("t5_busy0", busy, 0);
    check("t5_data0", ser_data, 0);
    check("t5_cnt0", frame_cnt, 0);
    model_ptr = NR - 1;
    frames = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    done_delay = 5;
    pend[1].push_back('h77);
    commit();
    wait_idle("t5_drain");
    check("t5_cnt", frame_cnt, 16'(frames));

    // Stray done pulses in IDLE and in GAP are ignored.
    stray = 2;
    repeat (4) @(negedge clk);
    check("t6_idle_stray", frame_cnt, 16'(frames));
    dbl = 1'b1;
    done_delay = 3;
    pend[2].push_back('h66);
    commit();
    wait_idle("t6_drain");
    dbl = 1'b0;
    check("t6_gap_stray", frame_cnt, 16'(frames));

    // Counter wrap.
    @(negedge clk);
    force dut.frame_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.frame_cnt;
    @(negedge clk);
    frames = 'hFFFF;
    pend[0].push_back('h99);
    commit();
    wait_idle("t6_wrap_drain");
    check("t6_wrap", frame_cnt, 16'(frames));

    // Randomized bursts against the reference model.
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < NR; i++) begin
        int n;
        n = $urandom_range(0, 4);
        for (int j = 0; j < n; j++) pend[i].push_back($urandom_range(0, 255));
      end
      done_delay = $urandom_range(1, 12);
      commit();
      wait_idle("rand_drain");
      check("rand_cnt", frame_cnt, 16'(frames));
    end
    check("rand_err", timeout_err, 0);
    check("exp_left", expq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
